quad_decoder: RTL

Quadrature encoder front end that sits directly upstream of the team's 4-bit up/down counter. It synchronises and glitch-filters the A/B encoder channels and decodes Gray-code transitions. It emits a one-cycle count-enable pulse plus a direction level that the counter consumes as its clock-enable and up inputs. Illegal transitions (both channels changing in one step) are flagged rather than counted.

---
 rtl/qdec_pkg.sv | 41 ++++
 rtl/quad_decoder_if.sv | 37 +++
 rtl/qdec_sync_filt.sv | 42 ++++
 rtl/quad_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and Gray-code step decoding for the quadrature decoder.
package qdec_pkg;

  typedef logic [1:0] ab_t;

  localparam ab_t S00 = 2'b00;
  localparam ab_t S10 = 2'b10;
  localparam ab_t S11 = 2'b11;
  localparam ab_t S01 = 2'b01;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;

  // Next state when the encoder turns in the "up" direction (A leads B).
  function automatic ab_t next_up(input ab_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      default: return S00;
    endcase
  endfunction

  function automatic step_t decode_step(input ab_t prev, input ab_t cur);
    step_t r;
    r = '0;
    if (prev != cur) begin
      if ((prev ^ cur) == 2'b11) begin
        r.illegal = 1'b1;
      end else begin
        r.valid = 1'b1;
        r.dir   = (cur == next_up(prev));
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder-side bus of the quadrature decoder; QDEC_INDEX_EN adds the z_in/idx_pulse pair.
interface quad_decoder_if;
  import qdec_pkg::*;

  logic en;
  logic a_in;
  logic b_in;
  logic err_clr;
  logic cnt_en;
  logic up;
  logic err_pulse;
  logic err_flag;
  ab_t  ab_filt;
`ifdef QDEC_INDEX_EN
  logic z_in;
  logic idx_pulse;
`endif

  modport master (
    output en, a_in, b_in, err_clr,
`ifdef QDEC_INDEX_EN
    output z_in,
    input  idx_pulse,
`endif
    input  cnt_en, up, err_pulse, err_flag, ab_filt
  );

  modport slave (
    input  en, a_in, b_in, err_clr,
`ifdef QDEC_INDEX_EN
    input  z_in,
    output idx_pulse,
`endif
    output cnt_en, up, err_pulse, err_flag, ab_filt
  );

endinterface

// File: rtl/qdec_sync_filt.sv
// One encoder channel: a plain flop synchroniser followed by a stability filter.
module qdec_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int FILT_W      = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic filt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      stable_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // A new level is accepted only after it has disagreed with filt for FILT_LEN cycles in a row.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (synced == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FILT_W'(FILT_LEN - 1)) begin
      filt       <= synced;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + FILT_W'(1);
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature front end: filtered A/B decode into count-enable, direction and error outputs.
// Optional index channel enabled by defining QDEC_INDEX_EN.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int FILT_W      = 4
) (
  input logic           clk,
  input logic           clr,
  quad_decoder_if.slave bus
);

  localparam int HOLD   = SYNC_STAGES + FILT_LEN + 1;
  localparam int HOLD_W = $clog2(HOLD + 1);

  logic              a_f;
  logic              b_f;
  ab_t               ab_filt;
  ab_t               prev;
  logic              primed;
  logic [HOLD_W-1:0] hold_cnt;
  step_t             step;
  logic              go;
  logic              cnt_en_q;
  logic              up_q;
  logic              err_pulse_q;
  logic              err_flag_q;

  qdec_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .FILT_W     (FILT_W)
  ) u_sf_a (
    .clk (clk),
    .clr (clr),
    .raw (bus.a_in),
    .filt(a_f)
  );

  qdec_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .FILT_W     (FILT_W)
  ) u_sf_b (
    .clk (clk),
    .clr (clr),
    .raw (bus.b_in),
    .filt(b_f)
  );

  assign ab_filt = {a_f, b_f};

  // Priming waits until a level present at reset release has crossed the synchroniser and
  // filter, so an encoder resting at 11 is absorbed into prev instead of decoding as 00->11.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hold_cnt <= '0;
      primed   <= 1'b0;
    end else if (!primed) begin
      if (hold_cnt == HOLD_W'(HOLD - 1)) begin
        primed <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_comb begin
    step = decode_step(prev, ab_filt);
    go   = primed & bus.en;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      prev        <= S00;
      cnt_en_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      up_q        <= 1'b1;
    end else begin
      prev        <= ab_filt;
      cnt_en_q    <= go & step.valid;
      err_pulse_q <= go & step.illegal;
      if (go & step.valid) begin
        up_q <= step.dir;
      end
      // A new error outranks a simultaneous clear so no event is ever lost.
      if (go & step.illegal) begin
        err_flag_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_flag_q <= 1'b0;
      end
    end
  end

  assign bus.cnt_en    = cnt_en_q;
  assign bus.up        = up_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.ab_filt   = ab_filt;

`ifdef QDEC_INDEX_EN
  logic z_f;
  logic z_prev;
  logic idx_q;

  qdec_sync_filt #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN),
    .FILT_W     (FILT_W)
  ) u_sf_z (
    .clk (clk),
    .clr (clr),
    .raw (bus.z_in),
    .filt(z_f)
  );

  // Same single register stage as cnt_en, so the index lines up with the step it marks.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      z_prev <= 1'b0;
      idx_q  <= 1'b0;
    end else begin
      z_prev <= z_f;
      idx_q  <= go & z_f & ~z_prev;
    end
  end

  assign bus.idx_pulse = idx_q;
`endif

endmodule
